// File: rtl/proc_pkg.sv
// Shared opcode constants and controller state encoding for param_proc.
package proc_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, carry and sign for one instruction.
module alu_core
  import proc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             cf,
  output logic             sf
);

  logic [WIDTH:0] sum;

  always_comb begin
    res = '0;
    cf  = 1'b0;
    sf  = 1'b0;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  {cf, res} = sum;
      // SUB reports the magnitude and flags a negative difference on sf
      OP_SUB: begin
        if (a >= b) begin
          res = a - b;
        end else begin
          res = b - a;
          sf  = 1'b1;
        end
      end
      OP_LOAD: res = imm;
      OP_XOR:  res = a ^ b;
      OP_SHL1: begin
        res = {a[WIDTH-2:0], 1'b0};
        cf  = a[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_proc.sv
// Four-state register-file processor: capture, operand fetch, execute, write back.
module param_proc
  import proc_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             cf,
  output logic             zf,
  output logic             sf,
  output logic             invalid
);

  state_t state, state_nxt;

  logic [2:0]       op_p0;
  logic [AW-1:0]    rd_p0, rs1_p0, rs2_p0;
  logic [WIDTH-1:0] imm_p0;
  logic [WIDTH-1:0] a_p1, b_p1;
  logic [WIDTH-1:0] regs [NREGS];

  logic [WIDTH-1:0] alu_res;
  logic             alu_cf, alu_sf;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a   (a_p1),
    .b   (b_p1),
    .imm (imm_p0),
    .op  (op_p0),
    .res (alu_res),
    .cf  (alu_cf),
    .sf  (alu_sf)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_p0   <= '0;
      rd_p0   <= '0;
      rs1_p0  <= '0;
      rs2_p0  <= '0;
      imm_p0  <= '0;
      a_p1    <= '0;
      b_p1    <= '0;
      res     <= '0;
      cf      <= 1'b0;
      zf      <= 1'b0;
      sf      <= 1'b0;
      invalid <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        // p0: instruction fields latched only when accepted from IDLE
        IDLE: begin
          if (start) begin
            op_p0  <= opcode;
            rd_p0  <= rd;
            rs1_p0 <= rs1;
            rs2_p0 <= rs2;
            imm_p0 <= wdata;
          end
        end
        // p1: operand fetch from the register file
        FETCH: begin
          a_p1 <= regs[rs1_p0];
          b_p1 <= regs[rs2_p0];
        end
        // p2: illegal opcode leaves result and flags untouched
        EXEC: begin
          if (op_p0 == OP_ILL) begin
            invalid <= 1'b1;
          end else begin
            res     <= alu_res;
            cf      <= alu_cf;
            sf      <= alu_sf;
            zf      <= (alu_res == '0);
            invalid <= 1'b0;
          end
        end
        // write back
        WB: begin
          if (op_p0 != OP_ILL) regs[rd_p0] <= res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_proc.sv
// Randomised and directed bench for param_proc against a behavioural model.
module tb_param_proc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] opcode = '0;
  logic [2:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, cf, zf, sf, invalid;
  logic [7:0] res;

  int n_checks = 0;
  int n_fail   = 0;

  int m_regs [8];
  int m_res, m_cf, m_zf, m_sf, m_inv;

  param_proc #(.WIDTH(8), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .wdata(wdata),
    .busy(busy), .done(done), .res(res),
    .cf(cf), .zf(zf), .sf(sf), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_res = 0; m_cf = 0; m_zf = 0; m_sf = 0; m_inv = 0;
  endtask

  task automatic model_exec(input int op, input int d, input int s1, input int s2, input int wd);
    int a, b, r;
    a = m_regs[s1];
    b = m_regs[s2];
    if (op == 7) begin
      m_inv = 1;
      return;
    end
    m_inv = 0; m_cf = 0; m_sf = 0; r = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: begin r = (a + b) % 256; m_cf = ((a + b) > 255) ? 1 : 0; end
      3: begin
        if (a >= b) r = a - b;
        else begin r = b - a; m_sf = 1; end
      end
      4: r = wd % 256;
      5: r = a ^ b;
      6: begin r = (a * 2) % 256; m_cf = (a >= 128) ? 1 : 0; end
      default: r = 0;
    endcase
    m_res = r;
    m_zf = (r == 0) ? 1 : 0;
    m_regs[d] = r;
  endtask

  // Drives one instruction from a negedge; reports first done cycle and pulse count.
  task automatic issue(input int op, input int d, input int s1, input int s2, input int wd,
                       input bit extra, output int lat, output int ndone);
    opcode = op[2:0]; rd = d[2:0]; rs1 = s1[2:0]; rs2 = s2[2:0]; wdata = wd[7:0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; ndone = 0;
    if (extra) begin
      start = 1'b1; opcode = 3'd4; rd = 3'd1; wdata = 8'h99;
    end
    for (int n = 1; n <= 6; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 2) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat == 0) lat = n;
      end
    end
    model_exec(op, d, s1, s2, wd);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; opcode = 3'd4; wdata = 8'hAA;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, res, cf, zf, sf, invalid} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b res=%h cf=%b zf=%b sf=%b inv=%b, want all 0",
               busy, done, res, cf, zf, sf, invalid);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
    model_reset();
  endtask

  task automatic test_directed();
    int lat, nd;
    issue(4, 1, 0, 0, 8'hF0, 0, lat, nd);
    n_checks++;
    if (lat !== 3 || nd !== 1) begin n_fail++; $display("FAIL load_r1_latency: lat=%0d dones=%0d want 3/1", lat, nd); end
    issue(4, 2, 0, 0, 8'h0F, 0, lat, nd);
    issue(1, 3, 1, 2, 0, 0, lat, nd);
    n_checks++;
    if (res !== 8'hFF || zf !== 1'b0 || lat !== 3) begin
      n_fail++; $display("FAIL or_r3: res=%h zf=%b lat=%0d want FF/0/3", res, zf, lat);
    end
    issue(1, 3, 3, 3, 0, 0, lat, nd);
    n_checks++;
    if (res !== 8'hFF) begin n_fail++; $display("FAIL read_r3: res=%h want FF", res); end
    issue(4, 4, 0, 0, 8'h20, 0, lat, nd);
    issue(2, 5, 1, 4, 0, 0, lat, nd);
    n_checks++;
    if (res !== 8'h10 || cf !== 1'b1 || sf !== 1'b0) begin
      n_fail++; $display("FAIL add_carry: res=%h cf=%b sf=%b want 10/1/0", res, cf, sf);
    end
    issue(6, 6, 1, 1, 0, 0, lat, nd);
    n_checks++;
    if (res !== 8'hE0 || cf !== 1'b1) begin
      n_fail++; $display("FAIL shl1: res=%h cf=%b want E0/1", res, cf);
    end
    issue(3, 7, 2, 1, 0, 0, lat, nd);
    n_checks++;
    if (res !== 8'hE1 || sf !== 1'b1 || cf !== 1'b0) begin
      n_fail++; $display("FAIL sub_neg: res=%h sf=%b cf=%b want E1/1/0", res, sf, cf);
    end
    issue(3, 7, 1, 1, 0, 0, lat, nd);
    n_checks++;
    if (res !== 8'h00 || zf !== 1'b1 || sf !== 1'b0) begin
      n_fail++; $display("FAIL sub_zero: res=%h zf=%b sf=%b want 00/1/0", res, zf, sf);
    end
  endtask

  task automatic test_invalid();
    int lat, nd;
    issue(7, 3, 1, 2, 8'hAA, 0, lat, nd);
    n_checks++;
    if (invalid !== 1'b1 || res !== 8'h00 || zf !== 1'b1 || cf !== 1'b0 || sf !== 1'b0 || nd !== 1) begin
      n_fail++;
      $display("FAIL illegal_op: inv=%b res=%h zf=%b cf=%b sf=%b dones=%0d want 1/00/1/0/0/1",
               invalid, res, zf, cf, sf, nd);
    end
    issue(0, 3, 3, 3, 0, 0, lat, nd);
    n_checks++;
    if (invalid !== 1'b0 || res !== 8'hFF) begin
      n_fail++; $display("FAIL and_after_illegal: inv=%b res=%h want 0/FF", invalid, res);
    end
  endtask

  task automatic test_start_ignored();
    int lat, nd;
    issue(5, 0, 1, 2, 0, 1, lat, nd);
    n_checks++;
    if (nd !== 1 || res !== 8'hFF) begin
      n_fail++; $display("FAIL start_in_fetch: dones=%0d res=%h want 1/FF", nd, res);
    end
    issue(0, 1, 1, 1, 0, 0, lat, nd);
    n_checks++;
    if (res !== 8'hF0) begin n_fail++; $display("FAIL r1_untouched: res=%h want F0", res); end
  endtask

  task automatic test_reset_mid();
    int nd, lat;
    opcode = 3'd4; rd = 3'd1; wdata = 8'h55; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_checks++;
    if ({busy, done, res, cf, zf, sf, invalid} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b res=%h cf=%b zf=%b sf=%b inv=%b want all 0",
               busy, done, res, cf, zf, sf, invalid);
    end
    nd = 0;
    for (int n = 0; n < 5; n++) begin
      if (done) nd++;
      @(negedge clk);
    end
    n_checks++;
    if (nd !== 0) begin n_fail++; $display("FAIL reset_mid_done: dones=%0d want 0", nd); end
    issue(0, 1, 1, 1, 0, 0, lat, nd);
    n_checks++;
    if (res !== 8'h00 || zf !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_r1: res=%h zf=%b want 00/1", res, zf);
    end
  endtask

  task automatic test_random();
    int lat, nd, op, d, s1, s2, wd;
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(7, 0);
      if (k < 8) op = 4;
      d = $urandom_range(7, 0); s1 = $urandom_range(7, 0); s2 = $urandom_range(7, 0);
      wd = $urandom_range(255, 0);
      issue(op, d, s1, s2, wd, 0, lat, nd);
      n_checks++;
      if (res !== m_res[7:0] || cf !== m_cf[0] || zf !== m_zf[0] || sf !== m_sf[0] ||
          invalid !== m_inv[0] || lat !== 3 || nd !== 1) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d: res=%h cf=%b zf=%b sf=%b inv=%b lat=%0d dones=%0d want %h/%0d/%0d/%0d/%0d/3/1",
                 k, op, res, cf, zf, sf, invalid, lat, nd, m_res[7:0], m_cf, m_zf, m_sf, m_inv);
      end
    end
    for (int r = 0; r < 8; r++) begin
      issue(1, r, r, r, 0, 0, lat, nd);
      n_checks++;
      if (res !== m_regs[r][7:0]) begin
        n_fail++; $display("FAIL regfile_r%0d: got %h want %h", r, res, m_regs[r][7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nd, last;
    issue(4, 2, 0, 0, 3, 0, lat, nd);
    opcode = 3'd2; rd = 3'd2; rs1 = 3'd2; rs2 = 3'd2; start = 1'b1;
    nd = 0; last = 0;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (n == 9) start = 1'b0;
      if (done) begin nd++; last = n; end
    end
    repeat (3) model_exec(2, 2, 2, 2, 0);
    n_checks++;
    if (nd !== 3 || last !== 11 || res !== m_res[7:0]) begin
      n_fail++;
      $display("FAIL back_to_back: dones=%0d last=%0d res=%h want 3/11/%h", nd, last, res, m_res[7:0]);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_invalid();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_proc.md
PARAM_PROC -- requirements
Module: param_proc

Interface
REQ-001 Parameter WIDTH, default 8: datapath and register width in bits, minimum 4.
REQ-002 Parameter NREGS, default 8: register-file depth, a power of two, minimum 2; AW = clog2(NREGS).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 start  in  1  request to execute one instruction.
REQ-006 opcode  in  3  operation select.
REQ-007 rd, rs1, rs2  in  AW each  destination and source register indices.
REQ-008 wdata  in  WIDTH  immediate value used by LOAD.
REQ-009 busy  out  1  high while an instruction is in flight.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 res  out  WIDTH  last result.
REQ-012 cf, zf, sf, invalid  out  1 each  carry, zero, sign, and illegal-opcode flags.

Function
REQ-013 FSM states SHALL be: IDLE, FETCH, EXEC, WB.
- IDLE->FETCH when start=1.
- FETCH->EXEC, EXEC->WB and WB->IDLE unconditionally.
REQ-014 On the start edge: opcode, rd, rs1, rs2 and wdata SHALL be captured; start SHALL be ignored in any state other than IDLE.
REQ-015 FETCH: reg[rs1] and reg[rs2] SHALL be registered as operands A and B.
REQ-016 EXEC: res and flags SHALL be registered from the ALU.
REQ-017 WB: reg[rd] SHALL be written with res; done=1 for exactly the WB cycle.
REQ-018 Latency: done SHALL go high 3 cycles after the start edge; busy SHALL be high in FETCH, EXEC and WB.
REQ-019 Opcodes SHALL be:
- 000 AND, 001 OR, 010 ADD, 011 SUB, 100 LOAD (res=wdata), 101 XOR, 110 SHL1.
- 111 is illegal.
REQ-020 ADD: res = (A+B) mod 2^WIDTH; cf = carry out; sf = 0.
REQ-021 SUB:
- A>=B: res = A-B, sf = 0.
- A<B: res = B-A (magnitude), sf = 1.
- cf = 0 in both cases.
REQ-022 SHL1: res = A<<1; cf = A[WIDTH-1]; sf = 0.
REQ-023 AND, OR, XOR and LOAD: cf = 0, sf = 0.
REQ-024 zf SHALL equal (res==0) for every legal opcode.
REQ-025 Legal opcode: invalid SHALL be cleared in EXEC.
REQ-026 Opcode 111 in EXEC:
- invalid = 1; res, cf, zf and sf SHALL hold their previous values.
- No register write in WB; done still pulses.
REQ-027 Any register index may be both source and destination; the same index as rs1 and rs2 is legal.
REQ-028 A WB write SHALL be visible to an instruction started in the same cycle done=1; start may be asserted back-to-back.
REQ-029 Outputs SHALL hold their values between instructions.

Reset
REQ-030 rst=1 SHALL force, at the next edge:
- state = IDLE;
- every register-file entry, operand register and captured field = 0;
- res = 0; cf = zf = sf = invalid = busy = done = 0.
REQ-031 rst SHALL take priority over start and over every FSM state. Reset mid-instruction SHALL abort with no register write and no done pulse.

Structure
REQ-032 Package proc_pkg SHALL hold the opcode constants and the FSM state enumeration.
REQ-033 Sub-module alu_core (combinational, parametrised by WIDTH) SHALL compute res, cf and sf from A, B, wdata and opcode. param_proc SHALL own the FSM, the register file, zf and invalid.

Verification (WIDTH=8, NREGS=8)
REQ-034 The bench SHALL cover these directed scenarios:
- rst; LOAD r1=0xF0; LOAD r2=0x0F; OR r3,r1,r2 -> res=0xFF, zf=0, r3=0xFF, done 3 cycles after each start.
- LOAD r4=0x20; ADD r5,r1,r4 -> res=0x10, cf=1, sf=0; SHL1 r6,r1 -> res=0xE0, cf=1.
- SUB r7,r2,r1 -> res=0xE1, sf=1, cf=0; SUB r7,r1,r1 -> res=0x00, zf=1, sf=0.
- opcode=111 with rd=r3 -> invalid=1, r3 still 0xFF, res/flags unchanged, done pulses; the next AND clears invalid.
- start pulsed during FETCH -> ignored, only one done; rst asserted in EXEC of LOAD r1=0x55 -> no done, r1 reads 0, all outputs 0.
